axi_lite_desc_mem: RTL and testbench

- AXI4-Lite slave responder that acts as descriptor memory for the DMA engine's descriptor-fetch AXI-Lite master port; it is the other end of that master.
- Provides word-addressed RAM with byte-strobe writes, independent read and write channels, and programmable wait-state injection to stress the master's handshakes.
- Returns SLVERR for addresses outside its window.
- Used in the DMA bench and in the integration top; synthesizable.

---
 rtl/axi_lite_pkg.sv | 12 +
 rtl/sdp_ram_be.sv | 29 ++
 rtl/axi_lite_desc_mem.sv | 169 ++++++++++++++++
 tb/tb_axi_lite_desc_mem.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-Lite response codes and descriptor-memory FSM states
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_COMMIT, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;

endpackage

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple dual-port RAM, byte-enable write, registered read-before-write read
module sdp_ram_be #(
  parameter int    DEPTH     = 256,
  parameter int    WIDTH     = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports use non-blocking updates, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_desc_mem.sv
// rtl/axi_lite_desc_mem.sv - AXI4-Lite descriptor memory responder with wait-state injection
module axi_lite_desc_mem
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                    WR_WAIT    = 0,
  parameter int                    RD_WAIT    = 0,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IW = $clog2(DEPTH);

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q, ram_rdata;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic [3:0]              wr_cnt, rd_cnt;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, pair_next;
  logic                    aw_in_range, ar_in_range, ram_we, ram_re;
  logic                    unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, aw_addr_q[1:0], ar_addr_q[1:0]};

  // BASE_ADDR is DEPTH*4 aligned, so the window check is an upper-bit match.
  assign aw_in_range = aw_addr_q[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2];
  assign ar_in_range = ar_addr_q[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2];

  assign s_axi_awready = !areset && !aw_held;
  assign s_axi_wready  = !areset && !w_held;
  assign s_axi_arready = !areset && (rd_state == R_IDLE);

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign r_hs      = s_axi_rvalid && s_axi_rready;
  assign pair_next = (aw_held || aw_hs) && (w_held || w_hs);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_cnt   <= 4'd0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (wr_state == W_IDLE && pair_next) wr_cnt <= 4'(WR_WAIT);
      else if (wr_state == W_WAIT)         wr_cnt <= wr_cnt - 4'd1;
    end
  end

  always_comb begin
    wr_next      = wr_state;
    ram_we       = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = RESP_OKAY;
    case (wr_state)
      W_IDLE:   if (pair_next) wr_next = (WR_WAIT == 0) ? W_COMMIT : W_WAIT;
      W_WAIT:   if (wr_cnt == 4'd1) wr_next = W_COMMIT;
      W_COMMIT: begin
        ram_we  = aw_in_range && !areset;
        wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        if (s_axi_bready) wr_next = W_IDLE;
      end
      default:  wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        ar_addr_q <= s_axi_araddr;
        rd_cnt    <= 4'(RD_WAIT);
      end else if (rd_state == R_WAIT && rd_cnt != 4'd0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
    end
  end

  // Out-of-range reads still clock the RAM but the word is masked to zero.
  always_comb begin
    rd_next      = rd_state;
    ram_re       = 1'b0;
    s_axi_rvalid = 1'b0;
    s_axi_rresp  = RESP_OKAY;
    s_axi_rdata  = '0;
    case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_WAIT;
      R_WAIT: begin
        if (rd_cnt == 4'd0) begin
          ram_re  = 1'b1;
          rd_next = R_RESP;
        end
      end
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        s_axi_rdata  = ar_in_range ? ram_rdata : '0;
        if (r_hs) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  sdp_ram_be #(
    .DEPTH     (DEPTH),
    .WIDTH     (DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (aw_addr_q[2 +: IW]),
    .wdata (w_data_q),
    .wstrb (w_strb_q),
    .re    (ram_re),
    .raddr (ar_addr_q[2 +: IW]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_lite_desc_mem.sv
// tb/tb_axi_lite_desc_mem.sv - directed bench: instance 0 without waits, instance 1 with RD_WAIT=3/WR_WAIT=2
module tb_axi_lite_desc_mem;
  import axi_lite_pkg::*;

  logic        clk, areset;
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2];
  logic        bvalid [2], bready [2], arvalid [2], arready [2];
  logic        rvalid [2], rready [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_lite_desc_mem #(.WR_WAIT(0), .RD_WAIT(0)) dut (
    .aclk(clk), .areset(areset),
    .s_axi_awaddr(awaddr[0]), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
    .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
    .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
    .s_axi_araddr(araddr[0]), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
    .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0])
  );

  axi_lite_desc_mem #(.WR_WAIT(2), .RD_WAIT(3)) dut_w (
    .aclk(clk), .areset(areset),
    .s_axi_awaddr(awaddr[1]), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
    .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
    .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
    .s_axi_araddr(araddr[1]), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
    .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1])
  );

  // lat counts edges from the edge where the last of AW/W was accepted to bvalid seen.
  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    bit aw_fire, w_fire;
    int n;
    awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
    awvalid[k] = 1'b1; wvalid[k] = 1'b1; n = 0;
    while ((awvalid[k] || wvalid[k]) && n < 50) begin
      aw_fire = awvalid[k] && awready[k];
      w_fire  = wvalid[k] && wready[k];
      @(posedge clk); #1;
      if (aw_fire) awvalid[k] = 1'b0;
      if (w_fire)  wvalid[k]  = 1'b0;
      n++;
    end
    lat = 0;
    while (!bvalid[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    resp = bresp[k];
    bready[k] = 1'b1;
    @(posedge clk); #1;
    bready[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [31:0] a,
                         output logic [31:0] d, output logic [1:0] resp, output int lat);
    bit fire;
    int n;
    araddr[k] = a; arvalid[k] = 1'b1; n = 0;
    while (arvalid[k] && n < 50) begin
      fire = arready[k];
      @(posedge clk); #1;
      if (fire) arvalid[k] = 1'b0;
      n++;
    end
    lat = 0;
    while (!rvalid[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rdata[k];
    resp = rresp[k];
    rready[k] = 1'b1;
    @(posedge clk); #1;
    rready[k] = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({awready[k], wready[k], arready[k], bvalid[k], rvalid[k]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hs[%0d]: got %b want 00000", k, {awready[k], wready[k], arready[k], bvalid[k], rvalid[k]});
      end
      n_tests++;
      if ({rdata[k], bresp[k], rresp[k]} !== 36'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got rdata %h bresp %b rresp %b want zeros", k, rdata[k], bresp[k], rresp[k]);
      end
    end
    areset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({awready[k], wready[k], arready[k]} !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b want 111", k, {awready[k], wready[k], arready[k]});
      end
    end
  endtask

  task automatic test_write_read;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(0, 32'h10, 32'hCAFEF00D, 4'hF, resp, lat);
    n_tests++;
    if (resp !== RESP_OKAY || lat !== 1) begin
      n_fail++;
      $display("FAIL wr_basic: got resp %b lat %0d want 00 lat 1", resp, lat);
    end
    do_read(0, 32'h10, d, resp, lat);
    n_tests++;
    if (d !== 32'hCAFEF00D || resp !== RESP_OKAY || lat !== 1) begin
      n_fail++;
      $display("FAIL rd_basic: got %h/%b lat %0d want cafef00d/00 lat 1", d, resp, lat);
    end
  endtask

  task automatic test_partial_strobe;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(0, 32'h20, 32'h11223344, 4'hF, resp, lat);
    do_write(0, 32'h22, 32'hAABBCCDD, 4'b0101, resp, lat);
    do_read(0, 32'h20, d, resp, lat);
    n_tests++;
    if (d !== 32'h11BB33DD || resp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL partial_strobe: got %h/%b want 11bb33dd/00", d, resp);
    end
  endtask

  task automatic test_order_backpressure;
    logic [1:0] resp; logic [31:0] d; int lat; int n;
    wdata[0] = 32'h5; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({awready[0], wready[0], bvalid[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL w_first_hold: got aw/w/b %b want 100", {awready[0], wready[0], bvalid[0]});
    end
    awaddr[0] = 32'h8; awvalid[0] = 1'b1;
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    n = 0;
    while (!bvalid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if ({awready[0], wready[0], bvalid[0], bresp[0]} !== 5'b00100) begin
        n_fail++;
        $display("FAIL b_backpressure c%0d: got aw/w/b/resp %b want 00100", c, {awready[0], wready[0], bvalid[0], bresp[0]});
      end
      @(posedge clk); #1;
    end
    bready[0] = 1'b1;
    @(posedge clk); #1;
    bready[0] = 1'b0;
    n_tests++;
    if ({awready[0], wready[0], bvalid[0]} !== 3'b110) begin
      n_fail++;
      $display("FAIL b_release: got aw/w/b %b want 110", {awready[0], wready[0], bvalid[0]});
    end
    do_read(0, 32'h8, d, resp, lat);
    n_tests++;
    if (d !== 32'h5 || resp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL w_first_data: got %h/%b want 00000005/00", d, resp);
    end
  endtask

  task automatic test_out_of_range;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(0, 32'h0, 32'h12345678, 4'hF, resp, lat);
    do_write(0, 32'h400, 32'hDEADBEEF, 4'hF, resp, lat);
    n_tests++;
    if (resp !== RESP_SLVERR) begin
      n_fail++;
      $display("FAIL oor_bresp: got %b want 10", resp);
    end
    do_read(0, 32'h400, d, resp, lat);
    n_tests++;
    if (d !== 32'h0 || resp !== RESP_SLVERR) begin
      n_fail++;
      $display("FAIL oor_read: got %h/%b want 00000000/10", d, resp);
    end
    do_read(0, 32'h0, d, resp, lat);
    n_tests++;
    if (d !== 32'h12345678 || resp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL oor_no_alias: got %h/%b want 12345678/00", d, resp);
    end
    do_write(0, 32'h3FC, 32'h0F0F0F0F, 4'hF, resp, lat);
    do_read(0, 32'h3FC, d, resp, lat);
    n_tests++;
    if (d !== 32'h0F0F0F0F || resp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL last_word: got %h/%b want 0f0f0f0f/00", d, resp);
    end
  endtask

  task automatic test_wait_states;
    logic [1:0] resp; logic [31:0] d0; int lat;
    do_write(1, 32'h44, 32'h600DCAFE, 4'hF, resp, lat);
    n_tests++;
    if (resp !== RESP_OKAY || lat !== 3) begin
      n_fail++;
      $display("FAIL wr_wait: got resp %b lat %0d want 00 lat 3", resp, lat);
    end
    araddr[1] = 32'h44; arvalid[1] = 1'b1;
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    lat = 0;
    while (!rvalid[1] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d0 = rdata[1];
    n_tests++;
    if (lat !== 4 || d0 !== 32'h600DCAFE) begin
      n_fail++;
      $display("FAIL rd_wait: got lat %0d data %h want lat 4 data 600dcafe", lat, d0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h600DCAFE || arready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL r_hold c%0d: got rvalid %b rdata %h arready %b want 1/600dcafe/0", c, rvalid[1], rdata[1], arready[1]);
      end
    end
    rready[1] = 1'b1;
    @(posedge clk); #1;
    rready[1] = 1'b0;
    n_tests++;
    if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL r_release: got rvalid %b arready %b want 0/1", rvalid[1], arready[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(1, 32'h40, 32'h0BADF00D, 4'hF, resp, lat);
    awaddr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(posedge clk); #1;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({awready[1], wready[1], arready[1], bvalid[1]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_held: got aw/w/ar/b %b want 0000", {awready[1], wready[1], arready[1], bvalid[1]});
    end
    areset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({awready[1], wready[1], arready[1], bvalid[1]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_reset_release: got aw/w/ar/b %b want 1110", {awready[1], wready[1], arready[1], bvalid[1]});
    end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (bvalid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_b: got bvalid %b want 0", bvalid[1]);
    end
    do_read(1, 32'h40, d, resp, lat);
    n_tests++;
    if (d !== 32'h0BADF00D || resp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL mid_reset_ram: got %h/%b want 0badf00d/00", d, resp);
    end
  endtask

  initial begin
    clk = 1'b0;
    areset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      awaddr[k] = '0; wdata[k] = '0; wstrb[k] = '0; araddr[k] = '0;
      awvalid[k] = 1'b0; wvalid[k] = 1'b0; bready[k] = 1'b0;
      arvalid[k] = 1'b0; rready[k] = 1'b0;
    end
    test_reset;
    test_write_read;
    test_partial_strobe;
    test_order_backpressure;
    test_out_of_range;
    test_wait_states;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
